// File: rtl/dual_memory_pkg.sv
// dual_memory_pkg: geometry constants and shared types for the dual-port column RAM
package dual_memory_pkg;
   localparam int NUM_COL    = 4;
   localparam int COL_WIDTH  = 32;
   localparam int ADDR_WIDTH = 6;
   localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;
   localparam int DEPTH      = 2 ** ADDR_WIDTH;
   typedef logic [COL_WIDTH-1:0]  col_t;
   typedef logic [DATA_WIDTH-1:0] word_t;
   typedef logic [ADDR_WIDTH-1:0] addr_t;
endpackage

// File: rtl/dual_memory_bank.sv
// dual_memory_bank: one column-wide true-dual-port RAM with registered read-first outputs
// Build option DUAL_MEMORY_CLEAR_EN: array in flops, cleared by reset.
module dual_memory_bank
   import dual_memory_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_we_a,
   input  logic                  i_re_a,
   input  logic [ADDR_WIDTH-1:0] i_addr_a,
   input  logic [COL_WIDTH-1:0]  i_din_a,
   output logic [COL_WIDTH-1:0]  o_dout_a,
   input  logic                  i_we_b,
   input  logic                  i_re_b,
   input  logic [ADDR_WIDTH-1:0] i_addr_b,
   input  logic [COL_WIDTH-1:0]  i_din_b,
   output logic [COL_WIDTH-1:0]  o_dout_b
);
   logic [COL_WIDTH-1:0] r_mem [DEPTH];
   logic [COL_WIDTH-1:0] r_dout_a;
   logic [COL_WIDTH-1:0] r_dout_b;
`ifdef DUAL_MEMORY_CLEAR_EN
   // Array writes; reset wipes every word, port B written last so it wins a tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (i_we_a) r_mem[i_addr_a] <= i_din_a;
         if (i_we_b) r_mem[i_addr_b] <= i_din_b;
      end
   end
`else
   // Array writes without reset so the array maps onto block RAM
   always_ff @(posedge clk) begin
      if (i_we_a) r_mem[i_addr_a] <= i_din_a;
      if (i_we_b) r_mem[i_addr_b] <= i_din_b;
   end
`endif
   // Registered reads sample pre-edge contents, giving read-first behaviour
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dout_a <= '0;
         r_dout_b <= '0;
      end else begin
         if (i_re_a) r_dout_a <= r_mem[i_addr_a];
         if (i_re_b) r_dout_b <= r_mem[i_addr_b];
      end
   end
   assign o_dout_a = r_dout_a;
   assign o_dout_b = r_dout_b;
endmodule

// File: rtl/dual_memory.sv
// dual_memory: four-column true-dual-port RAM, full-word port A and single-column port B
// Build option DUAL_MEMORY_CLEAR_EN: array contents cleared by reset.
module dual_memory
   import dual_memory_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  En_A,
   input  logic [NUM_COL-1:0]    w_A,
   input  logic [ADDR_WIDTH-1:0] addrA,
   input  logic [DATA_WIDTH-1:0] dinA,
   output logic [DATA_WIDTH-1:0] doutA,
   input  logic                  En_B,
   input  logic [NUM_COL-1:0]    w_B,
   input  logic [NUM_COL-1:0]    r_B,
   input  logic [ADDR_WIDTH-1:0] addrB,
   input  logic [COL_WIDTH-1:0]  dinB,
   output logic [COL_WIDTH-1:0]  doutB
);
   localparam int SEL_W = $clog2(NUM_COL);
   logic                 w_en_a;
   logic                 w_en_b;
   logic                 w_same_addr;
   logic [NUM_COL-1:0]   w_we_a;
   logic [NUM_COL-1:0]   w_we_b;
   logic [NUM_COL-1:0]   w_re_b;
   logic [SEL_W-1:0]     w_sel;
   logic [SEL_W-1:0]     r_sel;
   logic [COL_WIDTH-1:0] w_dout_b [NUM_COL];
   assign w_en_a      = En_A & rst_n;
   assign w_en_b      = En_B & rst_n;
   assign w_same_addr = addrA == addrB;
   // Lowest set bit of r_B chooses the port B read column
   always_comb begin
      w_sel = '0;
      for (int i = NUM_COL - 1; i >= 0; i--) if (r_B[i]) w_sel = SEL_W'(i);
   end
   // Remember which column feeds doutB; unchanged when no column is read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sel <= '0;
      else if (En_B && |r_B) r_sel <= w_sel;
   end
   genvar c;
   for (c = 0; c < NUM_COL; c++) begin : g_col
      assign w_we_b[c] = w_en_b & w_B[c];
      assign w_we_a[c] = w_en_a & w_A[c] & ~(w_we_b[c] & w_same_addr);
      assign w_re_b[c] = En_B & (|r_B) & (w_sel == SEL_W'(c));
      dual_memory_bank u_bank (
         .clk      (clk),
         .rst_n    (rst_n),
         .i_we_a   (w_we_a[c]),
         .i_re_a   (En_A),
         .i_addr_a (addrA),
         .i_din_a  (dinA[c*COL_WIDTH +: COL_WIDTH]),
         .o_dout_a (doutA[c*COL_WIDTH +: COL_WIDTH]),
         .i_we_b   (w_we_b[c]),
         .i_re_b   (w_re_b[c]),
         .i_addr_b (addrB),
         .i_din_b  (dinB),
         .o_dout_b (w_dout_b[c])
      );
   end
   assign doutB = w_dout_b[r_sel];
endmodule

// File: tb/tb_dual_memory.sv
// tb_dual_memory: directed scoreboard bench for dual_memory
module tb_dual_memory;
   import dual_memory_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic En_A = 1'b0, En_B = 1'b0;
   logic [NUM_COL-1:0] w_A = '0, w_B = '0, r_B = '0;
   logic [ADDR_WIDTH-1:0] addrA = '0, addrB = '0;
   logic [DATA_WIDTH-1:0] dinA = '0, doutA;
   logic [COL_WIDTH-1:0] dinB = '0, doutB;
   typedef struct {
      bit    port_b;
      word_t v;
      string tag;
   } exp_t;
   exp_t exp_q[$];
   int n_chk = 0;
   int n_fail = 0;
   always #5 clk = ~clk;
   dual_memory dut (
      .clk   (clk),
      .rst_n (rst_n),
      .En_A  (En_A),
      .w_A   (w_A),
      .addrA (addrA),
      .dinA  (dinA),
      .doutA (doutA),
      .En_B  (En_B),
      .w_B   (w_B),
      .r_B   (r_B),
      .addrB (addrB),
      .dinB  (dinB),
      .doutB (doutB)
   );
   task automatic step(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   function automatic void exp_a(string t, word_t v);
      exp_q.push_back('{port_b: 1'b0, v: v, tag: t});
   endfunction
   function automatic void exp_b(string t, col_t v);
      exp_q.push_back('{port_b: 1'b1, v: word_t'(v), tag: t});
   endfunction
   task automatic check();
      exp_t e;
      word_t got;
      e = exp_q.pop_front();
      got = e.port_b ? word_t'(doutB) : doutA;
      n_chk++;
      assert (got === e.v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", e.tag, got, e.v);
      end
   endtask
   initial begin
      col_t vals [4];
      vals = '{32'h1, 32'h3, 32'h7, 32'hF};
      #2;
      exp_a("rst_doutA", '0); check();
      exp_b("rst_doutB", '0); check();
      step();
      rst_n = 1'b1;
      step();
      // port A column-by-column write to addr 0
      En_A = 1'b1; addrA = '0; dinA = {4{32'h1}};
      for (int i = 0; i < 4; i++) begin
         w_A = 4'(1 << i);
         step();
      end
      w_A = '0;
      step(2);
      exp_a("a_colwise", {4{32'h1}}); check();
      // port B write then read each column of addr 1
      En_B = 1'b1; addrB = 6'd1;
      for (int i = 0; i < 4; i++) begin
         w_B = 4'(1 << i); dinB = vals[i]; r_B = '0;
         step();
         w_B = '0; r_B = 4'(1 << i);
         step();
         exp_b($sformatf("b_col%0d", i), vals[i]); check();
      end
      // several r_B bits set: lowest index wins (col 1 = 3)
      r_B = 4'b1010;
      step();
      exp_b("b_lowest", 32'h3); check();
      // r_B = 0 holds doutB
      r_B = '0;
      step();
      exp_b("b_hold_r0", 32'h3); check();
      // En_B = 0: no write, doutB holds
      En_B = 1'b0; w_B = 4'hF; dinB = 32'hDEAD_BEEF; r_B = 4'b0001;
      step();
      exp_b("b_hold_en0", 32'h3); check();
      En_B = 1'b1; w_B = '0;
      step();
      exp_b("b_en0_nowrite", 32'h1); check();
      // cross-port visibility at addr 2
      addrA = 6'd2; dinA = {32'hD3, 32'hC2, 32'hB1, 32'hA0}; w_A = 4'hF;
      step();
      w_A = '0; En_A = 1'b0;
      addrB = 6'd2; w_B = 4'b0100; dinB = 32'hA5A5_A5A5; r_B = '0;
      step();
      w_B = '0; En_A = 1'b1;
      step();
      exp_a("a_sees_b", {32'hD3, 32'hA5A5_A5A5, 32'hB1, 32'hA0}); check();
      // port A reads addr 2 while B writes it: old data returned
      w_B = 4'b0001; dinB = 32'hEE;
      step();
      w_B = '0;
      exp_a("a_cross_old", {32'hD3, 32'hA5A5_A5A5, 32'hB1, 32'hA0}); check();
      step();
      exp_a("a_cross_new", {32'hD3, 32'hA5A5_A5A5, 32'hB1, 32'hEE}); check();
      // collision at addr 5 column 0: B wins
      addrA = 6'd5; dinA = '0; w_A = 4'hF;
      step();
      dinA = {96'h0, 32'h1111}; w_A = 4'b0001;
      addrB = 6'd5; dinB = 32'h2222; w_B = 4'b0001;
      step();
      w_A = '0; w_B = '0; r_B = 4'b0001;
      step();
      exp_a("coll_a", {96'h0, 32'h2222}); check();
      exp_b("coll_b", 32'h2222); check();
      // port B read-first at addr 3
      addrA = 6'd3; dinA = {96'h0, 32'h5}; w_A = 4'hF; r_B = '0;
      step();
      w_A = '0;
      addrB = 6'd3; dinB = 32'h9; w_B = 4'b0001; r_B = 4'b0001;
      step();
      exp_b("b_rdfirst_old", 32'h5); check();
      w_B = '0;
      step();
      exp_b("b_rdfirst_new", 32'h9); check();
      // port A read-first at addr 0
      addrA = '0; dinA = {4{32'h7}}; w_A = 4'hF;
      step();
      exp_a("a_rdfirst_old", {4{32'h1}}); check();
      w_A = '0;
      step();
      exp_a("a_rdfirst_new", {4{32'h7}}); check();
      // asynchronous reset between edges
      rst_n = 1'b0;
      #1;
      exp_a("rst_async_a", '0); check();
      exp_b("rst_async_b", '0); check();
      addrB = 6'd1; w_B = 4'b1000; dinB = 32'hBAD; r_B = '0;
      step();
      rst_n = 1'b1; w_B = '0; r_B = 4'b1000;
      step();
`ifdef DUAL_MEMORY_CLEAR_EN
      exp_b("post_rst_col3", 32'h0); check();
`else
      exp_b("post_rst_col3", 32'hF); check();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/dual_memory.md
# dual_memory

True dual-port, column-writable synchronous RAM in the UHCI host-controller datapath. Port A is a full-width (four-DWord) port; port B is a single-DWord port that selects one column per access. Both ports share one clock and one asynchronous active-low reset. Either side can assemble or consume descriptor/data words written by the other.

## Interface
- NUM_COL, 4, columns (DWords) per word
- COL_WIDTH, 32, bits per column
- ADDR_WIDTH, 6, address bits; depth = 2**ADDR_WIDTH = 64 words
- DATA_WIDTH, NUM_COL*COL_WIDTH = 128, port A word width (derived, not overridden)
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low, synchronous release
- En_A  in  1  port A enable; no read/write when 0
- w_A  in  NUM_COL  port A per-column write enables; bit i writes dinA column i
- addrA  in  ADDR_WIDTH  port A word address
- dinA  in  DATA_WIDTH  port A write data; column i = bits [i*COL_WIDTH +: COL_WIDTH]
- doutA  out  DATA_WIDTH  port A registered read data, full word
- En_B  in  1  port B enable
- w_B  in  NUM_COL  port B column write select; dinB is written to every set column
- r_B  in  NUM_COL  port B column read select, one-hot
- addrB  in  ADDR_WIDTH  port B word address
- dinB  in  COL_WIDTH  port B write data
- doutB  out  COL_WIDTH  port B registered read data, one column

## Operation
- Port A, rising clk with En_A=1:
  - every column i with w_A[i]=1 stores dinA column i at addrA;
  - doutA loads the full word at addrA.
- Port B, rising clk with En_B=1:
  - every column i with w_B[i]=1 stores dinB at addrB column i;
  - doutB loads the column selected by r_B at addrB.
- r_B must be one-hot. If several bits are set, the lowest set index wins. If r_B=0, doutB holds its value.
- En_X=0: no write, doutX holds.
- Same-port read of a location written in the same cycle is read-first: dout returns the old contents.
- Cross-port collision (same address, same column, both writing, same edge): port B data is stored.
- A read on one port of a location written by the other port in the same cycle returns the old contents.
- Address wraps naturally; there are no out-of-range addresses.

## Timing
- Write: data is visible in the array after the write edge.
- Read latency: 1 cycle. dout shows array contents as of the edge where the read was sampled.
- Write-then-read of the same column: write at edge N, read issued at N+1, data on dout after N+1.
- Reset (rst_n=0, any time, asynchronous): doutA=0 and doutB=0 immediately.
  - Array contents are retained, unless DUAL_MEMORY_CLEAR_EN is defined.
  - Writes in progress during reset are discarded.
- No handshake; accesses are accepted every cycle.

## Configuration
- DUAL_MEMORY_CLEAR_EN defined:
  - the array is built from flops;
  - asynchronous reset clears every word to 0.
  - A read issued after reset release returns 0 until the location is written.
- Not defined:
  - the array has no reset and is inferable as block RAM;
  - contents after power-up are undefined;
  - reset affects only doutA/doutB.

## Structure
- Package dual_memory_pkg holds:
  - NUM_COL, COL_WIDTH, ADDR_WIDTH defaults;
  - derived DATA_WIDTH and DEPTH;
  - typedefs col_t (COL_WIDTH bits), word_t (DATA_WIDTH bits), addr_t.
- Sub-module dual_memory_bank: one COL_WIDTH-wide true-dual-port column RAM with per-port write enable and registered read, instantiated NUM_COL times.
- The top level handles:
  - w_A/w_B fan-out per column;
  - r_B one-hot to column mux;
  - the cross-port priority rule.

## Test plan
- Port A column-by-column write: En_A=1, addrA=0, dinA={4{32'h1}}, w_A=0001, 0010, 0100, 1000 on consecutive edges, then w_A=0 for 2 cycles -> doutA=128'h00000001_00000001_00000001_00000001.
- Port B write/read each column: addrB=1; dinB=1/3/7/F written with w_B=0001/0010/0100/1000; each followed by the matching r_B one-hot -> doutB=1, 3, 7, F respectively, 2 cycles later.
- Cross-port visibility: port B writes 32'hA5A5A5A5 to addr 2 column 2 -> port A read of addr 2 returns that value in bits [95:64], other columns unchanged.
- Collision: both ports write addr 5 column 0 on the same edge, A=32'h1111, B=32'h2222 -> subsequent reads return 32'h2222.
- Read-first: addr 3 holds 32'h5; port B writes 32'h9 and reads column 0 at the same edge -> doutB=32'h5, next read gives 32'h9.
- Reset mid-operation: assert rst_n=0 between edges after reads -> doutA=0 and doutB=0 immediately.
  - Without the macro: addr 1 still reads 32'hF at column 3.
  - With DUAL_MEMORY_CLEAR_EN: it reads 0.
